overdrive_shaper: RTL

Parametrised, multi-mode waveshaper for the synth FX chain that handles bypass, hard clip (compression), overdrive (clip plus makeup gain) and soft-knee clip. It takes signed samples through a valid/ready stream. The makeup gain max_amplitude/threshold is computed by an internal sequential divider, so there is no combinational divide. It sits between the oscillator/voice mixer output and the volume/DAC stage.

---
 rtl/overdrive_pkg.sv | 17 +
 rtl/seq_divider.sv | 78 +++++++
 rtl/overdrive_shaper.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared encodings for the overdrive_shaper waveshaper.
//   MODE_*  : per-sample shaping mode as presented on the mode input.
//   state_t : control FSM states (gain calculation, streaming, pipeline drain).
package overdrive_pkg;

  localparam logic [1:0] MODE_BYPASS    = 2'd0;
  localparam logic [1:0] MODE_CLIP      = 2'd1;
  localparam logic [1:0] MODE_OVERDRIVE = 2'd2;
  localparam logic [1:0] MODE_SOFT      = 2'd3;

  typedef enum logic [1:0] {
    ST_CALC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   clk, reset (sync, active-low)
//   start    : load operands (restarts an operation already in progress)
//   dividend : DVD_W-bit unsigned numerator
//   divisor  : DVS_W-bit unsigned denominator
//   busy     : iteration in progress
//   done     : high during the final iteration cycle
//   quotient : result, valid while done is high; all-ones on divide-by-zero
//              or when the quotient does not fit in QUO_W bits
// One load cycle plus DVD_W iteration cycles per division.
module seq_divider #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 15,
  parameter int QUO_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [CW-1:0]    cnt;
  logic [DVS_W:0]   rem;
  logic [DVS_W-1:0] dvs;
  logic [DVD_W-1:0] dvd;
  logic [DVD_W-1:0] quo;

  logic [DVS_W:0]   shifted;
  logic             ge;
  logic [DVS_W:0]   rem_nxt;
  logic [DVD_W-1:0] quo_nxt;
  logic [DVD_W:0]   quo_ext;
  logic             ovf;

  // Bring down the next dividend bit; subtract the divisor only if it fits.
  assign shifted = (rem << 1) | {{DVS_W{1'b0}}, dvd[DVD_W-1]};
  assign ge      = (shifted >= {1'b0, dvs});
  assign rem_nxt = ge ? (shifted - {1'b0, dvs}) : shifted;
  assign quo_nxt = (quo << 1) | DVD_W'(ge);
  assign quo_ext = {1'b0, quo_nxt};
  assign ovf     = ((quo_ext >> QUO_W) != '0);

  assign done     = busy && (cnt == CW'(1));
  assign quotient = ((dvs == '0) || ovf) ? '1 : QUO_W'(quo_nxt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(DVD_W);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      dvd <= dividend;
      dvs <= divisor;
      quo <= '0;
    end else if (busy) begin
      rem <= rem_nxt;
      dvd <= dvd << 1;
      quo <= quo_nxt;
    end
  end

endmodule

// File: rtl/overdrive_shaper.sv
// overdrive_shaper: multi-mode waveshaper (bypass, hard clip, overdrive with
// makeup gain, soft-knee clip) on a valid/ready sample stream.
//   clk, reset (sync, active-low)
//   activate      : 0 forces bypass for samples accepted while low
//   mode          : 0 bypass, 1 hard clip, 2 overdrive, 3 soft clip
//   threshold     : clip magnitude (unsigned, WIDTH-1 bits)
//   max_amplitude : overdrive target peak / saturation (unsigned, WIDTH-1 bits)
//   in_valid/in_ready/in_sample    : signed input stream
//   out_valid/out_ready/out_sample : signed output stream
//   busy          : high whenever the block is not streaming (CALC or DRAIN)
// The makeup gain max_amplitude*2^FRAC/threshold comes from a sequential
// divider run whenever the parameters change; samples already in the pipe
// finish with the gain and parameters they were accepted under.
module overdrive_shaper
  import overdrive_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int KNEE_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic [1:0]       mode,
  input  logic [WIDTH-2:0] threshold,
  input  logic [WIDTH-2:0] max_amplitude,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sample,
  output logic             busy
);

  localparam int TW = WIDTH - 1;
  localparam int GW = TW + FRAC;
  localparam int MW = WIDTH + 1;  // magnitude of the most-negative input fits
  localparam int PW = MW + GW;
  localparam logic [MW-1:0] PEAK  = MW'((1 << (WIDTH - 1)) - 1);
  localparam logic [GW-1:0] UNITY = GW'(1) << FRAC;

  function automatic logic [MW-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic signed [MW-1:0] xe;
    xe = x;
    return (xe < 0) ? $unsigned(-xe) : $unsigned(xe);
  endfunction

  function automatic logic [MW-1:0] shape(input logic [MW-1:0] m,
                                          input logic [1:0]    md,
                                          input logic [TW-1:0] thr);
    logic [MW-1:0] t;
    t = MW'(thr);
    if (md == MODE_BYPASS) return m;
    if (thr == '0) return '0;
    if (md == MODE_SOFT) return (m <= t) ? m : t + ((m - t) >> KNEE_SHIFT);
    return (m < t) ? m : t;
  endfunction

  // Gain is applied to the magnitude, so the shift truncates toward zero.
  function automatic logic [MW-1:0] makeup(input logic [MW-1:0] c,
                                           input logic [GW-1:0] g,
                                           input logic [TW-1:0] lim);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(g);
    prod = prod >> FRAC;
    return (prod > PW'(lim)) ? MW'(lim) : MW'(prod);
  endfunction

  // Bypass keeps the input as-is (including the most-negative code).
  function automatic logic signed [WIDTH-1:0] saturate(input logic [MW-1:0] m,
                                                       input logic          neg,
                                                       input logic          bypass);
    logic [MW-1:0] lim;
    lim = (!bypass && (m > PEAK)) ? PEAK : m;
    return neg ? $signed(WIDTH'(-lim)) : $signed(WIDTH'(lim));
  endfunction

  state_t state_q, state_d;

  logic [TW-1:0] thr_r, max_r;
  logic [GW-1:0] gain_r;
  logic          params_changed;
  logic          div_start, div_busy, div_done, calc_done;
  logic [GW-1:0] div_quot;

  logic          vld_p1, vld_p2;
  logic          adv_p1, adv_p2, accept;
  logic [1:0]    eff_mode;
  logic [MW-1:0] shaped;
  logic [MW-1:0] mag_p1;
  logic          neg_p1;
  logic [1:0]    mode_p1;
  logic [MW-1:0] mag_s2;
  logic signed [WIDTH-1:0] res_s2;
  logic signed [WIDTH-1:0] data_p2;

  assign params_changed = (threshold != thr_r) || (max_amplitude != max_r);
  assign div_start      = (state_q == ST_CALC) && (!div_busy || params_changed);
  assign calc_done      = (state_q == ST_CALC) && div_done && !params_changed;

  seq_divider #(
    .DVD_W(GW),
    .DVS_W(TW),
    .QUO_W(GW)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend ({max_amplitude, {FRAC{1'b0}}}),
    .divisor  (threshold),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_CALC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CALC:  if (calc_done) state_d = ST_RUN;
      ST_RUN:   if (params_changed) state_d = ST_DRAIN;
      ST_DRAIN: if (!vld_p1 && !vld_p2) state_d = ST_CALC;
      default:  state_d = ST_CALC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (div_start) begin
      thr_r <= threshold;
      max_r <= max_amplitude;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)         gain_r <= UNITY;
    else if (calc_done) gain_r <= div_quot;
  end

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = (state_q == ST_RUN) && !params_changed && adv_p1;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_RUN);

  assign eff_mode = activate ? mode : MODE_BYPASS;
  assign shaped   = shape(magnitude(in_sample), eff_mode, thr_r);

  // Stage 1: clipped / knee magnitude, sign and effective mode
  always_ff @(posedge clk) begin
    if (!reset)      vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && accept) begin
      mag_p1  <= shaped;
      neg_p1  <= in_sample[WIDTH-1];
      mode_p1 <= eff_mode;
    end
  end

  assign mag_s2 = (mode_p1 == MODE_OVERDRIVE) ? makeup(mag_p1, gain_r, max_r) : mag_p1;
  assign res_s2 = saturate(mag_s2, neg_p1, mode_p1 == MODE_BYPASS);

  // Stage 2: gain, sign restore and saturation
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= res_s2;
    end
  end

  assign out_valid  = vld_p2;
  assign out_sample = data_p2;

endmodule
